// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: grant encoding and default widths shared by the rom arbiter files
package rom_arbiter_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 32;
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IF = 2'd1;
  localparam logic [1:0] GNT_DBG = 2'd2;
endpackage

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: two-way grant picker (if_req, dbg_req, last_gnt -> gnt), round-robin when ROM_ARB_RR_EN is defined, else fixed IF priority
module rom_arb_pick
  import rom_arbiter_pkg::*;
(
  input  logic       if_req,
  input  logic       dbg_req,
  input  logic [1:0] last_gnt,
  output logic [1:0] gnt
);
`ifdef ROM_ARB_RR_EN
  logic if_wins;
  assign if_wins = last_gnt != GNT_IF;
`else
  logic if_wins;
  logic unused_last_gnt;
  assign if_wins = 1'b1;
  assign unused_last_gnt = ^last_gnt;
`endif
  always_comb gnt = (if_req && (!dbg_req || if_wins)) ? GNT_IF : dbg_req ? GNT_DBG : GNT_NONE;
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between IF and DBG read ports, same-cycle grant, registered response one cycle later (conflict rule set by ROM_ARB_RR_EN)
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);
  logic [1:0] pick, gnt, last_gnt, resp_owner;
  logic [DATA_W-1:0] if_q, dbg_q;
  rom_arb_pick u_pick (.if_req(if_req), .dbg_req(dbg_req), .last_gnt(last_gnt), .gnt(pick));
  assign gnt = rst ? GNT_NONE : pick;
  assign if_gnt = gnt == GNT_IF;
  assign dbg_gnt = gnt == GNT_DBG;
  assign rom_ce = if_gnt || dbg_gnt;
  assign rom_addr = if_gnt ? if_addr : dbg_gnt ? dbg_addr : '0;
  assign if_rvalid = !rst && resp_owner == GNT_IF;
  assign dbg_rvalid = !rst && resp_owner == GNT_DBG;
  assign if_rdata = rst ? '0 : if_q;
  assign dbg_rdata = rst ? '0 : dbg_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= GNT_DBG;
      resp_owner <= GNT_NONE;
      if_q <= '0;
      dbg_q <= '0;
    end else begin
      resp_owner <= gnt;
      if (gnt != GNT_NONE) last_gnt <= gnt;
      if (if_gnt) if_q <= rom_inst;
      if (dbg_gnt) dbg_q <= rom_inst;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: table-driven and scoreboard checks of rom_arbiter grants, ROM drive and responses
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;
  typedef struct packed {
    logic r;
    logic ir;
    logic [63:0] ia;
    logic dr;
    logic [63:0] da;
    logic [1:0] gf;
    logic [1:0] gr;
  } vec_t;
  typedef struct packed {
    logic [1:0] port;
    logic [31:0] data;
  } resp_t;
  logic clk = 1'b0, rst = 1'b1, if_req = 1'b0, dbg_req = 1'b0;
  logic [63:0] if_addr = '0, dbg_addr = '0, rom_addr;
  logic if_gnt, dbg_gnt, if_rvalid, dbg_rvalid, rom_ce;
  logic [31:0] if_rdata, dbg_rdata, rom_inst, exp_if, exp_dbg;
  logic [31:0] rom [16];
  vec_t vecs[$];
  resp_t q[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign rom_inst = rom_ce ? rom[rom_addr[5:2]] : 32'd0;
  rom_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic add(input logic r, input logic ir, input logic [63:0] ia, input logic dr, input logic [63:0] da, input logic [1:0] gf, input logic [1:0] gr);
    vec_t v;
    v.r = r;
    v.ir = ir;
    v.ia = ia;
    v.dr = dr;
    v.da = da;
    v.gf = gf;
    v.gr = gr;
    vecs.push_back(v);
  endtask
  task automatic cyc(input logic r, input logic ir, input logic [63:0] ia, input logic dr, input logic [63:0] da, input logic [1:0] eg);
    resp_t e, n;
    logic [63:0] ea;
    @(posedge clk);
    #1;
    rst = r;
    if_req = ir;
    if_addr = ia;
    dbg_req = dr;
    dbg_addr = da;
    #3;
    ea = eg == GNT_IF ? ia : eg == GNT_DBG ? da : 64'd0;
    if (q.size() > 0) e = q.pop_front();
    else begin
      e.port = GNT_NONE;
      e.data = 32'd0;
    end
    if (r) begin
      exp_if = 32'd0;
      exp_dbg = 32'd0;
    end else if (e.port == GNT_IF) exp_if = e.data;
    else if (e.port == GNT_DBG) exp_dbg = e.data;
    chk("if_gnt", 64'(if_gnt), 64'(eg == GNT_IF));
    chk("dbg_gnt", 64'(dbg_gnt), 64'(eg == GNT_DBG));
    chk("rom_ce", 64'(rom_ce), 64'(eg != GNT_NONE));
    chk("rom_addr", rom_addr, ea);
    chk("if_rvalid", 64'(if_rvalid), 64'(!r && e.port == GNT_IF));
    chk("dbg_rvalid", 64'(dbg_rvalid), 64'(!r && e.port == GNT_DBG));
    chk("if_rdata", 64'(if_rdata), 64'(exp_if));
    chk("dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg));
    n.port = eg;
    n.data = eg == GNT_NONE ? 32'd0 : rom[ea[5:2]];
    q.push_back(n);
  endtask
  initial begin
    logic [1:0] eg;
    for (int i = 0; i < 16; i++) rom[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0111;
    rom[2] = 32'h0000_0013;
    exp_if = 32'd0;
    exp_dbg = 32'd0;
    add(1, 1, 64'h0, 1, 64'h4, GNT_NONE, GNT_NONE);
    add(1, 1, 64'h0, 1, 64'h4, GNT_NONE, GNT_NONE);
    add(1, 1, 64'h0, 1, 64'h4, GNT_NONE, GNT_NONE);
    add(0, 1, 64'h0, 1, 64'h4, GNT_IF, GNT_IF);
    add(0, 1, 64'h8, 0, 64'h0, GNT_IF, GNT_IF);
    add(0, 0, 64'h0, 0, 64'h0, GNT_NONE, GNT_NONE);
    add(0, 0, 64'h0, 1, 64'hC, GNT_DBG, GNT_DBG);
    add(0, 1, 64'h0, 1, 64'h4, GNT_IF, GNT_IF);
    add(0, 1, 64'h0, 1, 64'h4, GNT_IF, GNT_DBG);
    add(0, 1, 64'h0, 1, 64'h4, GNT_IF, GNT_IF);
    add(0, 1, 64'h0, 1, 64'h4, GNT_IF, GNT_DBG);
    add(0, 0, 64'h0, 1, 64'h4, GNT_DBG, GNT_DBG);
    add(0, 1, 64'h14, 0, 64'h0, GNT_IF, GNT_IF);
    add(1, 1, 64'h18, 0, 64'h0, GNT_NONE, GNT_NONE);
    add(0, 0, 64'h0, 0, 64'h0, GNT_NONE, GNT_NONE);
    add(0, 1, 64'h1C, 1, 64'h24, GNT_IF, GNT_IF);
    for (int i = 0; i < 5; i++) add(0, 0, 64'h0, 0, 64'h0, GNT_NONE, GNT_NONE);
    add(0, 1, 64'hFFFF_0000_0000_0010, 0, 64'h0, GNT_IF, GNT_IF);
    add(0, 0, 64'h0, 1, 64'h8000_0000_0000_0007, GNT_DBG, GNT_DBG);
    add(0, 0, 64'h0, 0, 64'h0, GNT_NONE, GNT_NONE);
    for (int i = 0; i < vecs.size(); i++) begin
`ifdef ROM_ARB_RR_EN
      eg = vecs[i].gr;
`else
      eg = vecs[i].gf;
`endif
      cyc(vecs[i].r, vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].da, eg);
    end
    cyc(0, 1, 64'h0, 0, 64'h0, GNT_IF);
    cyc(0, 1, 64'h4, 0, 64'h0, GNT_IF);
    cyc(0, 1, 64'h8, 0, 64'h0, GNT_IF);
    cyc(0, 0, 64'h0, 1, 64'h30, GNT_DBG);
    cyc(1, 0, 64'h0, 0, 64'h0, GNT_NONE);
    cyc(0, 0, 64'h0, 0, 64'h0, GNT_NONE);
    cyc(0, 0, 64'h0, 1, 64'h3C, GNT_DBG);
    cyc(0, 0, 64'h0, 0, 64'h0, GNT_NONE);
    cyc(0, 0, 64'h0, 0, 64'h0, GNT_NONE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
